br_resolve_pipe: RTL
====================

// Module: br_resolve_pipe
// PURPOSE
//  Parametrised, pipelined branch resolution unit for the RV32I datapath; successor to the combinational comparator.
//  Evaluates the branch condition, computes the taken target and the fall-through PC, and checks the result against the fetch-stage prediction.
//  Sits between the EX operand latch and the control/redirect logic, with a valid/ready elastic pipeline and a flush input.
// PARAMETERS
//  XLEN     32  operand/PC width in bits
//  STAGES   1   registered stages, 1 or 2; any other value is an elaboration error
//  CNT_W    32  statistics counter width; only used with BR_STATS_EN
// PORTS
//  clk             in   1     clock; all state updates on the rising edge
//  rst             in   1     synchronous, active-high reset
//  flush           in   1     synchronous kill of all in-flight entries
//  in_valid        in   1     input entry valid
//  in_ready        out  1     unit accepts the entry this cycle
//  in_cmpop        in   3     branch_funct3_t (beq/bne/blt/bge/bltu/bgeu)
//  in_rs1,in_rs2   in   XLEN  compare operands
//  in_pc,in_imm    in   XLEN  branch PC and sign-extended B-immediate
//  in_pred_taken   in   1     fetch prediction: taken
//  in_pred_target  in   XLEN  fetch prediction: target
//  out_valid       out  1     result valid
//  out_ready       in   1     consumer accepts the result
//  out_br_en       out  1     branch condition true
//  out_target      out  XLEN  in_pc + in_imm
//  out_redirect_pc out  XLEN  out_br_en ? out_target : in_pc + 4
//  out_mispredict  out  1     the prediction was wrong
//  out_illegal     out  1     cmpop is not a branch funct3
//  stat_branches   out  CNT_W resolved branch count (BR_STATS_EN only)
//  stat_mispred    out  CNT_W mispredict count (BR_STATS_EN only)
// BEHAVIOUR
//  - Reset: all stage valids are 0, and every output (out_*, stat_*) is 0. in_ready is 1 on the first cycle after reset deasserts.
//  - Condition: beq/bne use equality; blt/bge use signed <; bltu/bgeu use unsigned <. Evaluated at full XLEN.
//  - Illegal cmpop (3'b010, 3'b011): out_illegal=1, out_br_en=0, out_mispredict=0. No simulation fatal.
//  - All adds wrap modulo 2^XLEN; carries are discarded.
//  - Mispredict: (br_en != pred_taken) | (br_en & pred_taken & pred_target != target).
//  - Handshake: an input transfers when in_valid & in_ready; an output transfers when out_valid & out_ready.
//  - Latency: a result appears exactly STAGES cycles after acceptance if the pipe does not stall.
//  - Each stage advances when its downstream slot is empty or is draining that cycle. Stages form a bubble-collapsing elastic chain.
//  - Full throughput is one entry per cycle.
//  - in_ready = ~flush & (stage0 empty | stage0 advancing). This is combinational from out_ready.
//  - Stall (out_valid & ~out_ready): every out_* holds stable. No entry is dropped or reordered.
//  - Payload registers load only on advance; the valid bit gates meaning.
//  - flush: every stage valid clears at the edge. out_valid is 0 on the next cycle.
//  - An input presented during a flush cycle is not accepted.
//  - An output handshake coincident with flush is complete and counts as delivered.
//  - rst has priority over flush and over all handshakes. Reset mid-stream discards everything.
// CONFIGURATION
//  BR_STATS_EN defined:
//  - stat_branches increments on each output transfer with out_illegal=0.
//  - stat_mispred increments on each such transfer with out_mispredict=1.
//  - Both counters saturate at all-ones and clear only on rst.
//  BR_STATS_EN undefined:
//  - The counters are not built, and stat_* are tied to 0.
//  - Datapath timing is identical in both builds.
// TESTING
//  1) beq rs1=5 rs2=5 pc=0x100 imm=0x20 pred_taken=0
//     -> after STAGES cycles: out_br_en=1, mispredict=1, redirect=0x120.
//  2) rs1=0xFFFFFFFF rs2=1: blt -> br_en=1; bltu -> br_en=0; bge -> 0; bgeu -> 1.
//  3) cmpop=3'b010 -> out_illegal=1, br_en=0, mispredict=0.
//     With BR_STATS_EN, counters do not change.
//  4) STAGES=2, 4 back-to-back inputs, out_ready=0 for 3 cycles
//     -> in_ready drops once the pipe is full; outputs are stable during the stall.
//     -> All 4 results are emitted in order, with none lost or duplicated.
//  5) 2 entries in flight, assert flush for 1 cycle
//     -> out_valid=0 the next cycle and nothing from them is emitted.
//     Repeat with rst instead: same result, counters read 0.
//  6) pc=0xFFFFFFF0 imm=0x20, beq taken -> target 0x10.
//     pc=0xFFFFFFFC, bne not-taken -> redirect 0x0.
//     Taken with pred_taken=1 and pred_target=0x14 -> mispredict=1.

Source files
------------

// File: rtl/br_resolve_pipe.sv
// br_resolve_pipe: pipelined RV32I branch resolution unit.
// Evaluates the branch condition, computes the taken target and the redirect PC,
// and checks the outcome against the fetch prediction, behind a valid/ready
// elastic pipe of STAGES (1 or 2) registered stages with a synchronous flush.
// Optional feature macro: BR_STATS_EN builds saturating resolve/mispredict counters.
module br_resolve_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_cmpop,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_br_en,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_redirect_pc,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispred
);

    typedef struct packed {
        logic            br_en;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] redirect_pc;
        logic            mispredict;
        logic            illegal;
    } res_t;

    if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
        $error("br_resolve_pipe: STAGES must be 1 or 2");
    end

    res_t res_c;
    logic eq_c;
    logic lt_c;
    logic ltu_c;

    // Resolve the branch from the input operands; everything is then only carried down the pipe.
    always_comb begin
        res_c             = '0;
        eq_c              = (in_rs1 == in_rs2);
        lt_c              = ($signed(in_rs1) < $signed(in_rs2));
        ltu_c             = (in_rs1 < in_rs2);
        res_c.target      = in_pc + in_imm;
        case (in_cmpop)
            3'b000:  res_c.br_en = eq_c;
            3'b001:  res_c.br_en = ~eq_c;
            3'b100:  res_c.br_en = lt_c;
            3'b101:  res_c.br_en = ~lt_c;
            3'b110:  res_c.br_en = ltu_c;
            3'b111:  res_c.br_en = ~ltu_c;
            default: res_c.illegal = 1'b1;
        endcase
        res_c.redirect_pc = res_c.br_en ? res_c.target : in_pc + XLEN'(4);
        res_c.mispredict  = ~res_c.illegal &
                            ((res_c.br_en != in_pred_taken) |
                             (res_c.br_en & in_pred_taken & (in_pred_target != res_c.target)));
    end

    logic s0_v;
    res_t s0_d;
    logic s0_acc_c;
    logic tail_acc_c;
    logic last_v;
    res_t last_d;

    // Stage 0 can take a new entry when empty or when its contents move on this cycle.
    assign s0_acc_c = ~s0_v | tail_acc_c;
    assign in_ready = ~flush & s0_acc_c;

    // First pipeline stage: captures the resolved result on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_v <= 1'b0;
            s0_d <= '0;
        end else if (flush) begin
            s0_v <= 1'b0;
        end else if (s0_acc_c) begin
            s0_v <= in_valid;
            if (in_valid) s0_d <= res_c;
        end
    end

    if (STAGES == 2) begin : g_two
        logic s1_v;
        res_t s1_d;

        assign tail_acc_c = ~s1_v | out_ready;

        // Output stage: takes stage 0 whenever it is empty or draining.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_v <= 1'b0;
                s1_d <= '0;
            end else if (flush) begin
                s1_v <= 1'b0;
            end else if (tail_acc_c) begin
                s1_v <= s0_v;
                if (s0_v) s1_d <= s0_d;
            end
        end

        assign last_v = s1_v;
        assign last_d = s1_d;
    end else begin : g_one
        assign tail_acc_c = out_ready;
        assign last_v     = s0_v;
        assign last_d     = s0_d;
    end

    assign out_valid       = last_v;
    assign out_br_en       = last_d.br_en;
    assign out_target      = last_d.target;
    assign out_redirect_pc = last_d.redirect_pc;
    assign out_mispredict  = last_d.mispredict;
    assign out_illegal     = last_d.illegal;

`ifdef BR_STATS_EN
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mp_cnt;
    logic             xfer_c;

    // A delivered legal result counts even when it coincides with a flush.
    assign xfer_c = last_v & out_ready & ~last_d.illegal;

    // Saturating statistics counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else if (xfer_c) begin
            if (br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
            if (last_d.mispredict && mp_cnt != '1) mp_cnt <= mp_cnt + CNT_W'(1);
        end
    end

    assign stat_branches = br_cnt;
    assign stat_mispred  = mp_cnt;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule
